// File: rtl/stq_drain_pkg.sv
// Shared store-queue drain definitions: entry index type, FSM states,
// queue depth and payload widths.
package stq_drain_pkg;

  localparam int WQ_DEPTH = 64;
  localparam int IDX_W    = $clog2(WQ_DEPTH);
  localparam int ADATA_W  = 64;
  localparam int DATA_W   = 136;
  localparam int BNK_W    = 32;
  localparam int CNT_W    = IDX_W + 1;

  typedef logic [IDX_W-1:0] wq_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WB   = 2'd2
  } drain_state_t;

  // One-hot entry mask, all zeros when en is low.
  function automatic logic [WQ_DEPTH-1:0] idx_onehot(input wq_idx_t idx, input logic en);
    logic [WQ_DEPTH-1:0] m;
    m      = '0;
    m[idx] = en;
    return m;
  endfunction

endpackage

// File: rtl/stq_drain_if.sv
// Dcache write-port bundle: two request groups sharing one ready.
// The drain engine is the master, the dcache write arbiter the slave.
interface stq_drain_if;
  import stq_drain_pkg::*;

  logic               wb0_en;
  logic [ADATA_W-1:0] wb0_adata;
  logic [DATA_W-1:0]  wb0_data;
  logic [BNK_W-1:0]   wb0_bnkEn;
  wq_idx_t            wb0_LSQ;
  logic               wb1_en;
  logic [ADATA_W-1:0] wb1_adata;
  logic [DATA_W-1:0]  wb1_data;
  logic [BNK_W-1:0]   wb1_bnkEn;
  wq_idx_t            wb1_LSQ;
  logic               wb_rdy;

  modport master (
    output wb0_en, wb0_adata, wb0_data, wb0_bnkEn, wb0_LSQ,
    output wb1_en, wb1_adata, wb1_data, wb1_bnkEn, wb1_LSQ,
    input  wb_rdy
  );

  modport slave (
    input  wb0_en, wb0_adata, wb0_data, wb0_bnkEn, wb0_LSQ,
    input  wb1_en, wb1_adata, wb1_data, wb1_bnkEn, wb1_LSQ,
    output wb_rdy
  );

endinterface

// File: rtl/stq_drain_popcnt.sv
// Combinational population count of the passed-entry vector.
module stq_drain_popcnt #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 7
) (
  input  logic [IN_W-1:0]  vec,
  output logic [OUT_W-1:0] cnt
);

  // Sum of all set bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < IN_W; i++) begin
      cnt = cnt + OUT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/stq_drain.sv
// stq_drain: drains retired ("passed") stores strictly in order from the
// store-queue head to the dcache write ports, then frees their entries.
// Optional dual-port pairing of head and head+1 is enabled by defining
// STQ_DRAIN_PAIR_EN; without it only wb0 is used and head advances by one.
module stq_drain
  import stq_drain_pkg::*;
#(
  parameter int WQ_DEPTH = 64,
  parameter int ADATA_W  = 64,
  parameter int DATA_W   = 136,
  parameter int BNK_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pse0_en,
  input  wq_idx_t             pse0_WQ,
  input  logic                pse1_en,
  input  wq_idx_t             pse1_WQ,
  output wq_idx_t             rd_idx0,
  output wq_idx_t             rd_idx1,
  input  logic [ADATA_W-1:0]  rd_adata0,
  input  logic [ADATA_W-1:0]  rd_adata1,
  input  logic [DATA_W-1:0]   rd_data0,
  input  logic [DATA_W-1:0]   rd_data1,
  input  logic [BNK_W-1:0]    rd_bnkEn0,
  input  logic [BNK_W-1:0]    rd_bnkEn1,
  stq_drain_if.master         wb,
  output logic [WQ_DEPTH-1:0] free_en,
  output wq_idx_t             head,
  output logic [CNT_W-1:0]    pend_cnt
);

`ifdef STQ_DRAIN_PAIR_EN
  localparam bit PAIR_EN = 1'b1;
`else
  localparam bit PAIR_EN = 1'b0;
`endif

  drain_state_t        state_q, state_d;
  logic [WQ_DEPTH-1:0] passed_q, passed_d;
  wq_idx_t             head_q, head_d;
  logic                pair_q, pair_d;
  logic [WQ_DEPTH-1:0] free_q, free_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;

  logic                wb0_en_q, wb0_en_d;
  logic [ADATA_W-1:0]  wb0_adata_q, wb0_adata_d;
  logic [DATA_W-1:0]   wb0_data_q, wb0_data_d;
  logic [BNK_W-1:0]    wb0_bnk_q, wb0_bnk_d;
  wq_idx_t             wb0_lsq_q, wb0_lsq_d;
  logic                wb1_en_q, wb1_en_d;
  logic [ADATA_W-1:0]  wb1_adata_q, wb1_adata_d;
  logic [DATA_W-1:0]   wb1_data_q, wb1_data_d;
  logic [BNK_W-1:0]    wb1_bnk_q, wb1_bnk_d;
  wq_idx_t             wb1_lsq_q, wb1_lsq_d;

  logic                issue;
  wq_idx_t             head_nxt;
  logic [WQ_DEPTH-1:0] set_mask;
  logic [WQ_DEPTH-1:0] clr_mask;

  stq_drain_popcnt #(
    .IN_W  (WQ_DEPTH),
    .OUT_W (CNT_W)
  ) u_popcnt (
    .vec (passed_q),
    .cnt (pend_cnt_d)
  );

  // Next-state, drain control and passed-bit bookkeeping.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    pair_d      = pair_q;
    free_d      = '0;
    wb0_en_d    = wb0_en_q;
    wb0_adata_d = wb0_adata_q;
    wb0_data_d  = wb0_data_q;
    wb0_bnk_d   = wb0_bnk_q;
    wb0_lsq_d   = wb0_lsq_q;
    wb1_en_d    = wb1_en_q;
    wb1_adata_d = wb1_adata_q;
    wb1_data_d  = wb1_data_q;
    wb1_bnk_d   = wb1_bnk_q;
    wb1_lsq_d   = wb1_lsq_q;
    issue       = 1'b0;
    clr_mask    = '0;
    head_nxt    = head_q + wq_idx_t'(1);
    set_mask    = idx_onehot(pse0_WQ, pse0_en) | idx_onehot(pse1_WQ, pse1_en);

    case (state_q)
      ST_IDLE: begin
        // Only the head entry may start a drain; later passed entries wait.
        if (passed_q[head_q]) begin
          issue   = 1'b1;
          pair_d  = PAIR_EN && passed_q[head_nxt];
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        // Entry contents arrive now, one cycle after the read index.
        wb0_en_d    = 1'b1;
        wb0_adata_d = rd_adata0;
        wb0_data_d  = rd_data0;
        wb0_bnk_d   = rd_bnkEn0;
        wb0_lsq_d   = head_q;
        // A bank overlap drops the second store; it drains in the next group.
        wb1_en_d    = pair_q && ((rd_bnkEn0 & rd_bnkEn1) == '0);
        wb1_adata_d = wb1_en_d ? rd_adata1 : '0;
        wb1_data_d  = wb1_en_d ? rd_data1  : '0;
        wb1_bnk_d   = wb1_en_d ? rd_bnkEn1 : '0;
        wb1_lsq_d   = wb1_en_d ? head_nxt  : '0;
        state_d     = ST_WB;
      end
      ST_WB: begin
        // Payload holds until the cache accepts the whole group.
        if (wb.wb_rdy) begin
          wb0_en_d = 1'b0;
          wb1_en_d = 1'b0;
          clr_mask = idx_onehot(head_q, 1'b1) | idx_onehot(head_nxt, wb1_en_q);
          free_d   = clr_mask;
          head_d   = wb1_en_q ? (head_q + wq_idx_t'(2)) : head_nxt;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new pass notification beats a same-cycle clear of that entry.
    passed_d = (passed_q & ~clr_mask) | set_mask;
  end

  // All state, including the wb payload, clears asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      passed_q    <= '0;
      head_q      <= '0;
      pair_q      <= 1'b0;
      free_q      <= '0;
      pend_cnt_q  <= '0;
      wb0_en_q    <= 1'b0;
      wb0_adata_q <= '0;
      wb0_data_q  <= '0;
      wb0_bnk_q   <= '0;
      wb0_lsq_q   <= '0;
      wb1_en_q    <= 1'b0;
      wb1_adata_q <= '0;
      wb1_data_q  <= '0;
      wb1_bnk_q   <= '0;
      wb1_lsq_q   <= '0;
    end else begin
      state_q     <= state_d;
      passed_q    <= passed_d;
      head_q      <= head_d;
      pair_q      <= pair_d;
      free_q      <= free_d;
      pend_cnt_q  <= pend_cnt_d;
      wb0_en_q    <= wb0_en_d;
      wb0_adata_q <= wb0_adata_d;
      wb0_data_q  <= wb0_data_d;
      wb0_bnk_q   <= wb0_bnk_d;
      wb0_lsq_q   <= wb0_lsq_d;
      wb1_en_q    <= wb1_en_d;
      wb1_adata_q <= wb1_adata_d;
      wb1_data_q  <= wb1_data_d;
      wb1_bnk_q   <= wb1_bnk_d;
      wb1_lsq_q   <= wb1_lsq_d;
    end
  end

  assign rd_idx0  = issue ? head_q   : '0;
  assign rd_idx1  = issue ? head_nxt : '0;
  assign free_en  = free_q;
  assign head     = head_q;
  assign pend_cnt = pend_cnt_q;

  assign wb.wb0_en    = wb0_en_q;
  assign wb.wb0_adata = wb0_adata_q;
  assign wb.wb0_data  = wb0_data_q;
  assign wb.wb0_bnkEn = wb0_bnk_q;
  assign wb.wb0_LSQ   = wb0_lsq_q;
  assign wb.wb1_en    = PAIR_EN ? wb1_en_q    : 1'b0;
  assign wb.wb1_adata = PAIR_EN ? wb1_adata_q : '0;
  assign wb.wb1_data  = PAIR_EN ? wb1_data_q  : '0;
  assign wb.wb1_bnkEn = PAIR_EN ? wb1_bnk_q   : '0;
  assign wb.wb1_LSQ   = PAIR_EN ? wb1_lsq_q   : '0;

endmodule

// File: tb/tb_stq_drain.sv
// Bench for stq_drain: directed pass notifications, a store-queue array
// model, and a scoreboard monitor checking each dcache write group.
// Honours STQ_DRAIN_PAIR_EN to select paired or single-port expectations.
module tb_stq_drain;
  import stq_drain_pkg::*;

`ifdef STQ_DRAIN_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic pse0_en, pse1_en;
  wq_idx_t pse0_WQ, pse1_WQ, rd_idx0, rd_idx1;
  logic [ADATA_W-1:0] rd_adata0, rd_adata1;
  logic [DATA_W-1:0]  rd_data0, rd_data1;
  logic [BNK_W-1:0]   rd_bnkEn0, rd_bnkEn1;
  logic [WQ_DEPTH-1:0] free_en;
  wq_idx_t head;
  logic [CNT_W-1:0] pend_cnt;

  stq_drain_if wb();

  stq_drain dut (
    .clk(clk), .rst(rst),
    .pse0_en(pse0_en), .pse0_WQ(pse0_WQ), .pse1_en(pse1_en), .pse1_WQ(pse1_WQ),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1),
    .rd_adata0(rd_adata0), .rd_adata1(rd_adata1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_bnkEn0(rd_bnkEn0), .rd_bnkEn1(rd_bnkEn1),
    .wb(wb), .free_en(free_en), .head(head), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Store-queue array model: contents appear the cycle after the index.
  logic [BNK_W-1:0] bnk_tab [WQ_DEPTH];

  function automatic logic [ADATA_W-1:0] f_adata(input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0000_0001_0000_0101);
  endfunction

  function automatic logic [DATA_W-1:0] f_data(input int i);
    return {8'h5A, 64'(i) ^ 64'hFFFF_0000_1234_0000, 64'(i) << 4};
  endfunction

  always @(posedge clk) begin
    rd_adata0 <= f_adata(int'(rd_idx0));
    rd_adata1 <= f_adata(int'(rd_idx1));
    rd_data0  <= f_data(int'(rd_idx0));
    rd_data1  <= f_data(int'(rd_idx1));
    rd_bnkEn0 <= bnk_tab[rd_idx0];
    rd_bnkEn1 <= bnk_tab[rd_idx1];
  end

  typedef struct {
    int          lsq0;
    bit          en1;
    int          lsq1;
    logic [63:0] free;
    int          head;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_fail = 0;
  bit free_pend = 1'b0;
  logic [63:0] exp_free;
  int exp_head;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input int l0, input bit e1, input logic [63:0] fr, input int hd);
    exp_t e;
    e.lsq0 = l0;
    e.en1  = e1;
    e.lsq1 = (l0 + 1) % 64;
    e.free = fr;
    e.head = hd;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor, sampling 1 time unit after the falling edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      free_pend = 1'b0;
    end else begin
      if (free_pend) begin
        chk("free_en", 256'(free_en), 256'(exp_free));
        chk("head_after", 256'(head), 256'(exp_head));
        free_pend = 1'b0;
      end else begin
        chk("free_idle", 256'(free_en), 256'(0));
      end
      if (wb.wb0_en) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL wb_unexpected: wb0_en=1 LSQ=%0d, required no request", wb.wb0_LSQ);
        end else begin
          e = sbq[0];
          chk("wb0_LSQ", 256'(wb.wb0_LSQ), 256'(e.lsq0));
          chk("wb0_adata", 256'(wb.wb0_adata), 256'(f_adata(e.lsq0)));
          chk("wb0_data", 256'(wb.wb0_data), 256'(f_data(e.lsq0)));
          chk("wb0_bnkEn", 256'(wb.wb0_bnkEn), 256'(bnk_tab[e.lsq0]));
          chk("wb1_en", 256'(wb.wb1_en), 256'(e.en1));
          if (e.en1) begin
            chk("wb1_LSQ", 256'(wb.wb1_LSQ), 256'(e.lsq1));
            chk("wb1_adata", 256'(wb.wb1_adata), 256'(f_adata(e.lsq1)));
            chk("wb1_data", 256'(wb.wb1_data), 256'(f_data(e.lsq1)));
            chk("wb1_bnkEn", 256'(wb.wb1_bnkEn), 256'(bnk_tab[e.lsq1]));
          end
          if (wb.wb_rdy) begin
            void'(sbq.pop_front());
            free_pend = 1'b1;
            exp_free  = e.free;
            exp_head  = e.head;
          end
        end
      end
    end
  end

  task automatic pass2(input int a, input bit ea, input int b, input bit eb);
    pse0_en = ea;
    pse0_WQ = wq_idx_t'(a);
    pse1_en = eb;
    pse1_WQ = wq_idx_t'(b);
    @(negedge clk);
    pse0_en = 1'b0;
    pse1_en = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((sbq.size() != 0 || free_pend) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (sbq.size() != 0 || free_pend) begin
      n_fail++;
      $display("FAIL drain_%s: %0d groups outstanding after %0d cycles, required 0", nm, sbq.size(), n);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bit two;
    logic [63:0] m;
    rst = 1'b1;
    pse0_en = 1'b0; pse1_en = 1'b0; pse0_WQ = '0; pse1_WQ = '0;
    wb.wb_rdy = 1'b0;
    for (int k = 0; k < WQ_DEPTH; k++) bnk_tab[k] = 32'h1 << (k % 32);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wb0_en", 256'(wb.wb0_en), 256'(0));
    chk("rst_wb1_en", 256'(wb.wb1_en), 256'(0));
    chk("rst_head", 256'(head), 256'(0));
    chk("rst_pend_cnt", 256'(pend_cnt), 256'(0));
    chk("rst_free_en", 256'(free_en), 256'(0));
    rst = 1'b0;
    wb.wb_rdy = 1'b1;
    @(negedge clk);

    // Single drain of entry 0: wb0_en three cycles after the pass
    push_exp(0, 1'b0, 64'h1, 1);
    pse0_en = 1'b1; pse0_WQ = '0;
    @(negedge clk);
    pse0_en = 1'b0;
    chk("lat_n1_wb0_en", 256'(wb.wb0_en), 256'(0));
    chk("lag_pend_cnt0", 256'(pend_cnt), 256'(0));
    @(negedge clk);
    chk("lat_n2_wb0_en", 256'(wb.wb0_en), 256'(0));
    chk("lag_pend_cnt1", 256'(pend_cnt), 256'(1));
    @(negedge clk);
    chk("lat_n3_wb0_en", 256'(wb.wb0_en), 256'(1));
    wait_drain("single");

    // Entries 1..3, then head=4
    if (PAIR) begin
      push_exp(1, 1'b1, 64'h6, 3);
      push_exp(3, 1'b0, 64'h8, 4);
    end else begin
      push_exp(1, 1'b0, 64'h2, 2);
      push_exp(2, 1'b0, 64'h4, 3);
      push_exp(3, 1'b0, 64'h8, 4);
    end
    pass2(1, 1'b1, 2, 1'b1);
    pass2(3, 1'b1, 0, 1'b0);
    wait_drain("fill");

    // Pair 4/5 with disjoint banks
    bnk_tab[4] = 32'h1;
    bnk_tab[5] = 32'h2;
    if (PAIR) begin
      push_exp(4, 1'b1, 64'h30, 6);
    end else begin
      push_exp(4, 1'b0, 64'h10, 5);
      push_exp(5, 1'b0, 64'h20, 6);
    end
    pass2(4, 1'b1, 5, 1'b1);
    wait_drain("pair");

    // Bank conflict on 6/7: entry 7 waits for the next group
    bnk_tab[6] = 32'h1;
    bnk_tab[7] = 32'h1;
    push_exp(6, 1'b0, 64'h40, 7);
    push_exp(7, 1'b0, 64'h80, 8);
    pass2(6, 1'b1, 7, 1'b1);
    wait_drain("conflict");

    // Backpressure: pass 8..62 while the cache is not ready
    wb.wb_rdy = 1'b0;
    i = 8;
    while (i < 63) begin
      two = PAIR && (i + 1 <= 62);
      m = (64'h1 << i) | (two ? (64'h1 << (i + 1)) : 64'h0);
      push_exp(i, two, m, two ? i + 2 : i + 1);
      i = two ? i + 2 : i + 1;
    end
    for (int k = 8; k <= 62; k += 2) pass2(k, 1'b1, k + 1, (k + 1) <= 62);
    repeat (6) @(negedge clk);
    chk("bp_wb0_held", 256'(wb.wb0_en), 256'(1));
    chk("bp_head_held", 256'(head), 256'(8));
    wb.wb_rdy = 1'b1;
    wait_drain("bulk");

    // Wrap: 63 pairs with 0
    if (PAIR) begin
      push_exp(63, 1'b1, (64'h1 << 63) | 64'h1, 1);
    end else begin
      push_exp(63, 1'b0, 64'h1 << 63, 0);
      push_exp(0, 1'b0, 64'h1, 1);
    end
    pass2(63, 1'b1, 0, 1'b1);
    wait_drain("wrap");

    // Out-of-order: entry 3 passed while head=2 is not
    push_exp(1, 1'b0, 64'h2, 2);
    pass2(1, 1'b1, 0, 1'b0);
    wait_drain("to_head2");
    pass2(3, 1'b1, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk("ooo_no_issue", 256'(wb.wb0_en), 256'(0));
      @(negedge clk);
    end
    chk("ooo_pend_cnt", 256'(pend_cnt), 256'(1));
    chk("ooo_head", 256'(head), 256'(2));
    if (PAIR) begin
      push_exp(2, 1'b1, 64'hC, 4);
    end else begin
      push_exp(2, 1'b0, 64'h4, 3);
      push_exp(3, 1'b0, 64'h8, 4);
    end
    pass2(2, 1'b1, 0, 1'b0);
    wait_drain("ooo");

    // Reset in the middle of a stalled write
    wb.wb_rdy = 1'b0;
    push_exp(4, 1'b0, 64'h10, 5);
    pass2(4, 1'b1, 10, 1'b1);
    pass2(20, 1'b1, 0, 1'b0);
    i = 0;
    while (!wb.wb0_en && i < 10) begin
      @(negedge clk);
      i++;
    end
    chk("mid_wb0_en", 256'(wb.wb0_en), 256'(1));
    repeat (5) @(negedge clk);
    chk("mid_pend_cnt", 256'(pend_cnt), 256'(3));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wb0_en", 256'(wb.wb0_en), 256'(0));
    chk("arst_head", 256'(head), 256'(0));
    chk("arst_pend_cnt", 256'(pend_cnt), 256'(0));
    chk("arst_free_en", 256'(free_en), 256'(0));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    wb.wb_rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", 256'(wb.wb0_en), 256'(0));
    chk("sb_empty", 256'(sbq.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stq_drain.md
# stq_drain

Store-queue drain engine: the consumer side of the store queue's retire path. It takes the per-entry "passed" (retired) notifications `pse0`/`pse1` and drains passed stores strictly in order from the queue head. Each drained store is read from the store-queue arrays, presented to the L1 data-cache write ports `wb0`/`wb1` under a ready handshake, and its entry is returned as a `free_en` mask. It sits between the store queue and the dcache write arbiter.

## Interface
Parameters:
- `WQ_DEPTH`, 64: store-queue entries; the index is `$clog2(WQ_DEPTH)` = 6 bits.
- `ADATA_W`, 64: width of the packed address/attribute word.
- `DATA_W`, 136: store data width, bits 135:0.
- `BNK_W`, 32: bank-enable width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pse0_en`, `pse1_en` in 1: mark an entry passed.
- `pse0_WQ`, `pse1_WQ` in 6: entry index for each passed notification.
- `rd_idx0`, `rd_idx1` out 6: store-queue read indices.
- `rd_adata0/1` in ADATA_W, `rd_data0/1` in DATA_W, `rd_bnkEn0/1` in BNK_W: entry contents, valid the cycle after the index is driven.
- `wb0_en`, `wb1_en` out 1: write requests to the cache.
- `wb0_adata/wb1_adata` out ADATA_W, `wb0_data/wb1_data` out DATA_W, `wb0_bnkEn/wb1_bnkEn` out BNK_W, `wb0_LSQ/wb1_LSQ` out 6: request payload.
- `wb_rdy` in 1: the cache accepts every asserted `wb*_en` this cycle.
- `free_en` out WQ_DEPTH: one-cycle pulse per freed entry.
- `head` out 6: index of the oldest undrained entry.
- `pend_cnt` out 7: number of set passed bits.

## Operation
- `passed[63:0]` register.
  - Set on `pseN_en` at `pseN_WQ`; `pse0` and `pse1` at the same index set one bit.
  - Cleared on handshake for the drained entries.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Drain is strictly in order. Nothing issues unless `passed[head]`=1; later passed entries wait.
- FSM:
  - IDLE: if `passed[head]`, drive `rd_idx0=head`, `rd_idx1=head+1` (mod 64). Latch `pair = passed[head+1]`. Go to RD.
  - RD: capture `rd_*` into the wb output registers.
    - Drop the pair if `rd_bnkEn0 & rd_bnkEn1` != 0 (bank conflict).
    - `wbN_LSQ` = the read index.
    - Go to WB.
  - WB: hold `wb0_en`, and `wb1_en` if paired, with a stable payload until `wb_rdy`.
    - On `wb_rdy`: advance `head` by 1 or 2 (wraps 63→0), clear the drained passed bits, go to IDLE.
    - `free_en` pulses the next cycle with bits for the drained entries.
- Pairing at `head`=63 uses entry 0.
- `pend_cnt` is the registered popcount of `passed`.
- Reset mid-operation: every register clears asynchronously, `wb*_en` drops immediately, and in-flight requests are abandoned.

## Timing
- Reset values: all outputs 0, `head`=0, FSM=IDLE, `passed`=0.
- Minimum latency from `pse` at cycle N (entry at head) to `wb0_en`: IDLE at N+1, RD at N+2, `wb0_en` high at N+3.
- With `wb_rdy` held high, throughput is one request group per 3 cycles.
- `wb*_*` outputs are registered and stable while `wb*_en` && !`wb_rdy`.
- `free_en` is a single-cycle pulse, one cycle after the accepting edge.
- `pend_cnt` lags `passed` by one cycle.

## Configuration
- `STQ_DRAIN_PAIR_EN` defined: dual-port pairing as described above.
- `STQ_DRAIN_PAIR_EN` undefined:
  - `pair` is forced to 0, and `wb1_en` and the `wb1_*` payload are tied 0.
  - `rd_idx1` still drives `head+1` but is ignored.
  - `head` advances by 1 only.

## Structure
- Shared LSQ package: the entry-index typedef (6 bits), `WQ_DEPTH`, the FSM state enum (IDLE/RD/WB), and the bank-enable and data width constants.
- One sub-module, `stq_drain_popcnt`: a 64-bit popcount producing `pend_cnt`.

## Test plan
- Single drain: `pse0` at entry 0, `wb_rdy`=1.
  - `wb0_en` at N+3 with `wb0_LSQ`=0 and no `wb1_en`.
  - `free_en`=1<<0 at N+4; `head`=1.
- Pair: entries 4,5 passed, `head`=4, `bnkEn0`=0x1, `bnkEn1`=0x2.
  - `wb0_en` and `wb1_en` assert together with `LSQ` 4/5.
  - `free_en`=0x30; `head`=6.
- Bank conflict: same setup with both `bnkEn`=0x1.
  - Only `wb0` (entry 4) issues; entry 5 issues in the next group.
- Wrap and out-of-order passing.
  - `head`=63, with entries 63 and 0 passed: pair 63/0 issues, `free_en` = bit 63 | bit 0, `head`=1.
  - `passed[3]` set while `head`=2 and `passed[2]`=0: no issue.
- Backpressure and reset: `wb_rdy`=0 for 5 cycles.
  - Payload stays stable with no `free_en`.
  - Asserting `rst` mid-WB drops `wb0_en` at once, with `head`=0 and `pend_cnt`=0.
